// File: rtl/pipe_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : pipe_arbiter
//  Purpose  : Round-robin arbiter sharing one fixed-latency pipeline between
//             two requesters, with a tagged in-order response FIFO and
//             credit-based issue throttling so results can never be dropped.
//  Revision : 1.0  initial release
// ============================================================================
module pipe_arbiter #(
  parameter int W     = 32,
  parameter int LAT   = 2,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         req0_valid,
  output logic         req0_ready,
  input  logic [W-1:0] req0_a1,
  input  logic [W-1:0] req0_a2,
  input  logic [W-1:0] req0_b1,
  input  logic [W-1:0] req0_b2,
  input  logic         req1_valid,
  output logic         req1_ready,
  input  logic [W-1:0] req1_a1,
  input  logic [W-1:0] req1_a2,
  input  logic [W-1:0] req1_b1,
  input  logic [W-1:0] req1_b2,
  output logic         pipe_issue,
  output logic [W-1:0] pipe_a1,
  output logic [W-1:0] pipe_a2,
  output logic [W-1:0] pipe_b1,
  output logic [W-1:0] pipe_b2,
  input  logic [W-1:0] pipe_c,
  output logic         rsp_valid,
  input  logic         rsp_ready,
  output logic         rsp_id,
  output logic [W-1:0] rsp_c
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  // Wide enough to hold fifo occupancy plus in-flight issues without wrapping.
  localparam int CW = $clog2(DEPTH + LAT + 1) + 1;
  localparam logic [AW-1:0] C_PTR_LAST = AW'(DEPTH - 1);
  localparam logic [CW-1:0] C_DEPTH    = CW'(DEPTH);

  logic          r_tag_valid [LAT];
  logic          r_tag_id    [LAT];
  logic [CW-1:0] w_inflight;
  logic [CW-1:0] r_count;
  logic          r_last_grant;
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [W-1:0]  r_mem_c  [DEPTH];
  logic          r_mem_id [DEPTH];
  logic [W-1:0]  r_pipe_a1;
  logic [W-1:0]  r_pipe_a2;
  logic [W-1:0]  r_pipe_b1;
  logic [W-1:0]  r_pipe_b2;
  logic          w_allowed;
  logic          w_grant;
  logic          w_grant_id;
  logic          w_wr;
  logic          w_rd;

  // Count issues still travelling through the pipeline (tags not yet retired).
  always_comb begin
    w_inflight = '0;
    for (int i = 0; i < LAT; i++) begin
      w_inflight = w_inflight + CW'(r_tag_valid[i]);
    end
  end

  // Credit check ignores a same-cycle FIFO pop so rsp_ready never reaches
  // the request handshake combinationally. Reset forces everything idle.
  always_comb begin
    w_allowed  = rst_n && ((r_count + w_inflight) < C_DEPTH);
    w_grant    = w_allowed && (req0_valid || req1_valid);
    w_grant_id = (req0_valid && req1_valid) ? ~r_last_grant : req1_valid;
  end

  assign req0_ready = w_grant && !w_grant_id;
  assign req1_ready = w_grant &&  w_grant_id;
  assign pipe_issue = w_grant;

  // Operands pass straight through on a grant; otherwise the last issue holds.
  always_comb begin
    pipe_a1 = r_pipe_a1;
    pipe_a2 = r_pipe_a2;
    pipe_b1 = r_pipe_b1;
    pipe_b2 = r_pipe_b2;
    if (w_grant) begin
      pipe_a1 = w_grant_id ? req1_a1 : req0_a1;
      pipe_a2 = w_grant_id ? req1_a2 : req0_a2;
      pipe_b1 = w_grant_id ? req1_b1 : req0_b1;
      pipe_b2 = w_grant_id ? req1_b2 : req0_b2;
    end
  end

  // Remember the last issued operands and the last granted requester.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pipe_a1    <= '0;
      r_pipe_a2    <= '0;
      r_pipe_b1    <= '0;
      r_pipe_b2    <= '0;
      r_last_grant <= 1'b1;
    end else if (w_grant) begin
      r_pipe_a1    <= pipe_a1;
      r_pipe_a2    <= pipe_a2;
      r_pipe_b1    <= pipe_b1;
      r_pipe_b2    <= pipe_b2;
      r_last_grant <= w_grant_id;
    end
  end

  // First tag stage records each issue and which requester made it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_tag_valid[0] <= 1'b0;
      r_tag_id[0]    <= 1'b0;
    end else begin
      r_tag_valid[0] <= w_grant;
      r_tag_id[0]    <= w_grant_id;
    end
  end

  generate
    for (genvar k = 1; k < LAT; k++) begin : g_tag
      // Tags advance one stage per cycle in lockstep with the pipeline.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          r_tag_valid[k] <= 1'b0;
          r_tag_id[k]    <= 1'b0;
        end else begin
          r_tag_valid[k] <= r_tag_valid[k-1];
          r_tag_id[k]    <= r_tag_id[k-1];
        end
      end
    end
  endgenerate

  // The oldest tag coincides with pipe_c being valid for that issue.
  assign w_wr = r_tag_valid[LAT-1];
  assign w_rd = rsp_valid && rsp_ready;

  // FIFO storage; contents need no reset because the head is gated by count.
  always_ff @(posedge clk) begin
    if (w_wr) begin
      r_mem_c[r_wr_ptr]  <= pipe_c;
      r_mem_id[r_wr_ptr] <= r_tag_id[LAT-1];
    end
  end

  // FIFO pointers and occupancy; simultaneous push and pop leave count alone.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_wr) begin
        r_wr_ptr <= (r_wr_ptr == C_PTR_LAST) ? '0 : r_wr_ptr + AW'(1);
      end
      if (w_rd) begin
        r_rd_ptr <= (r_rd_ptr == C_PTR_LAST) ? '0 : r_rd_ptr + AW'(1);
      end
      r_count <= r_count + CW'(w_wr) - CW'(w_rd);
    end
  end

  assign rsp_valid = (r_count != '0);
  assign rsp_c     = rsp_valid ? r_mem_c[r_rd_ptr]  : '0;
  assign rsp_id    = rsp_valid ? r_mem_id[r_rd_ptr] : 1'b0;

  // Credit accounting must make a push into a full FIFO impossible.
  a_no_overflow : assert property (@(posedge clk) disable iff (!rst_n)
    !(w_wr && (r_count == C_DEPTH)));

endmodule
`default_nettype wire

// File: tb/tb_pipe_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_pipe_arbiter
//  Purpose  : Self-checking bench for pipe_arbiter with a LAT-cycle
//             multiply-accumulate pipeline model and a response scoreboard.
//  Revision : 1.0  initial release
// ============================================================================
module tb_pipe_arbiter;

  localparam int W     = 32;
  localparam int LAT   = 2;
  localparam int DEPTH = 4;

  typedef struct {
    logic         id;
    logic [W-1:0] c;
    int           rdy;
  } ent_t;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         req0_valid, req1_valid, req0_ready, req1_ready;
  logic [W-1:0] req0_a1, req0_a2, req0_b1, req0_b2;
  logic [W-1:0] req1_a1, req1_a2, req1_b1, req1_b2;
  logic         pipe_issue;
  logic [W-1:0] pipe_a1, pipe_a2, pipe_b1, pipe_b2, pipe_c;
  logic         rsp_valid, rsp_ready, rsp_id;
  logic [W-1:0] rsp_c;

  int           tests = 0;
  int           fails = 0;
  int           cyc = 0;
  int           issues = 0;
  ent_t         sb[$];
  logic         last_m = 1'b1;
  logic [4*W-1:0] held = '0;
  logic [W-1:0] pd [LAT];

  pipe_arbiter #(.W(W), .LAT(LAT), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_ready(req0_ready),
    .req0_a1(req0_a1), .req0_a2(req0_a2), .req0_b1(req0_b1), .req0_b2(req0_b2),
    .req1_valid(req1_valid), .req1_ready(req1_ready),
    .req1_a1(req1_a1), .req1_a2(req1_a2), .req1_b1(req1_b1), .req1_b2(req1_b2),
    .pipe_issue(pipe_issue),
    .pipe_a1(pipe_a1), .pipe_a2(pipe_a2), .pipe_b1(pipe_b1), .pipe_b2(pipe_b2),
    .pipe_c(pipe_c),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_c(rsp_c)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Shared pipeline model: c = a1*b1 + a2*b2, LAT cycles after issue.
  always @(posedge clk) begin
    pd[0] <= pipe_a1 * pipe_b1 + pipe_a2 * pipe_b2;
    for (int k = 1; k < LAT; k++) pd[k] <= pd[k-1];
  end
  assign pipe_c = pd[LAT-1];

  task automatic check(input string tag, input logic [4*W-1:0] got, input logic [4*W-1:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Cycle monitor: credit/round-robin model on the request side,
  // scoreboard ordering and latency on the response side.
  logic           m_ok, m_g, m_id, m_rv;
  logic [4*W-1:0] m_ops;
  always @(negedge clk) begin
    m_ok = rst_n && (sb.size() < DEPTH);
    m_g  = m_ok && (req0_valid || req1_valid);
    m_id = (req0_valid && req1_valid) ? ~last_m : req1_valid;
    check("issue", {127'd0, pipe_issue}, {127'd0, m_g});
    check("ready0", {127'd0, req0_ready}, {127'd0, m_g && !m_id});
    check("ready1", {127'd0, req1_ready}, {127'd0, m_g && m_id});
    m_rv = (sb.size() > 0) && (cyc >= sb[0].rdy);
    check("rsp_valid", {127'd0, rsp_valid}, {127'd0, m_rv});
    if (m_rv && rsp_valid) begin
      check("rsp_id", {127'd0, rsp_id}, {127'd0, sb[0].id});
      check("rsp_c", {96'd0, rsp_c}, {96'd0, sb[0].c});
      if (rsp_ready) void'(sb.pop_front());
    end
    if (m_g) begin
      m_ops = m_id ? {req1_a1, req1_a2, req1_b1, req1_b2}
                   : {req0_a1, req0_a2, req0_b1, req0_b2};
      check("pipe_ops", {pipe_a1, pipe_a2, pipe_b1, pipe_b2}, m_ops);
      sb.push_back('{id: m_id,
                     c: m_ops[4*W-1:3*W] * m_ops[2*W-1:W] + m_ops[3*W-1:2*W] * m_ops[W-1:0],
                     rdy: cyc + LAT + 1});
      last_m = m_id;
      held   = m_ops;
      issues++;
    end else begin
      check("pipe_hold", {pipe_a1, pipe_a2, pipe_b1, pipe_b2}, held);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_ready"}, {126'd0, req0_ready, req1_ready}, '0);
    check({tag, "_issue"}, {127'd0, pipe_issue}, '0);
    check({tag, "_rsp"}, {94'd0, rsp_valid, rsp_id, rsp_c}, '0);
    check({tag, "_pipe"}, {pipe_a1, pipe_a2, pipe_b1, pipe_b2}, '0);
  endtask

  // Asynchronous assert mid-cycle, release shortly after a later edge.
  task automatic pulse_reset();
    #2;
    rst_n  = 1'b0;
    sb.delete();
    last_m = 1'b1;
    held   = '0;
    #1;
    check_reset_outputs("async_rst");
    step();
    step();
    rst_n = 1'b1;
  endtask

  task automatic drain();
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    rsp_ready  = 1'b1;
    for (int i = 0; i < 60 && sb.size() != 0; i++) step();
    check("drain_empty", 128'(sb.size()), '0);
  endtask

  task automatic set_ops0(input logic [W-1:0] a1, b1, a2, b2);
    req0_a1 = a1; req0_b1 = b1; req0_a2 = a2; req0_b2 = b2;
  endtask

  task automatic set_ops1(input logic [W-1:0] a1, b1, a2, b2);
    req1_a1 = a1; req1_b1 = b1; req1_a2 = a2; req1_b2 = b2;
  endtask

  int base;

  initial begin
    rst_n = 1'b0;
    req0_valid = 1'b0; req1_valid = 1'b0; rsp_ready = 1'b1;
    set_ops0(0, 0, 0, 0);
    set_ops1(0, 0, 0, 0);
    #2;
    check_reset_outputs("init_rst");
    step(); step(); step();
    rst_n = 1'b1;

    // Single request from requester 0.
    set_ops0(0, 1, 2, 3);
    req0_valid = 1'b1;
    #1;
    check("single_ready", {126'd0, req0_ready, pipe_issue}, 128'd3);
    step();
    req0_valid = 1'b0;
    for (int i = 0; i < LAT; i++) step();
    check("single_rsp", {95'd0, rsp_valid, rsp_id, rsp_c}, {95'd0, 1'b1, 1'b0, 32'd6});
    drain();

    // Tie from reset: requester 0 first, then requester 1.
    pulse_reset();
    set_ops0(0, 1, 2, 3);
    set_ops1(3, 2, 1, 0);
    req0_valid = 1'b1; req1_valid = 1'b1;
    #1;
    check("tie_first", {126'd0, req0_ready, req1_ready}, 128'd2);
    step();
    check("tie_second", {126'd0, req0_ready, req1_ready}, 128'd1);
    step();
    drain();

    // Backpressure: exactly DEPTH issues, then resume when consumer returns.
    base = issues;
    rsp_ready = 1'b0;
    req0_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      set_ops0($urandom, $urandom, $urandom, $urandom);
      step();
    end
    check("bp_issue_count", 128'(issues - base), 128'(DEPTH));
    check("bp_ready_low", {127'd0, req0_ready}, '0);
    rsp_ready = 1'b1;
    for (int i = 0; i < 6; i++) step();
    check("bp_resumed", {127'd0, (issues - base) > DEPTH}, 128'd1);
    drain();

    // Streaming: both requesters valid for 20 cycles, consumer always ready.
    base = issues;
    req0_valid = 1'b1; req1_valid = 1'b1;
    for (int i = 0; i < 20; i++) begin
      set_ops0($urandom, $urandom, $urandom, $urandom);
      set_ops1($urandom, $urandom, $urandom, $urandom);
      step();
    end
    check("stream_count", 128'(issues - base), 128'd20);
    drain();

    // Reset with results both in flight and buffered.
    rsp_ready = 1'b0;
    req0_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      set_ops0($urandom, $urandom, $urandom, $urandom);
      step();
    end
    pulse_reset();
    req0_valid = 1'b0;
    rsp_ready  = 1'b1;
    for (int i = 0; i < LAT + 3; i++) step();
    check("post_rst_empty", {127'd0, rsp_valid}, '0);
    set_ops1(5, 7, 11, 13);
    req1_valid = 1'b1;
    step();
    req1_valid = 1'b0;
    drain();

    // Pointer wrap: 3*DEPTH issues with random stalls and random requesters.
    base = issues;
    for (int i = 0; i < 400 && (issues - base) < 3 * DEPTH; i++) begin
      req0_valid = 1'($urandom_range(0, 1));
      req1_valid = 1'($urandom_range(0, 1));
      rsp_ready  = ($urandom_range(0, 3) != 0);
      set_ops0($urandom, $urandom, $urandom, $urandom);
      set_ops1($urandom, $urandom, $urandom, $urandom);
      step();
    end
    check("wrap_count", {127'd0, (issues - base) >= 3 * DEPTH}, 128'd1);
    drain();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
